// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit and receive paths.
//   tx_state_t      : frame state encoding (IDLE/START/DATA/PARITY/STOP)
//   BAUD_CNT_W      : width of the per-bit clock counter
//   calc_bit_cycles : system clocks per line bit (integer division)
//   stop_bits_legal : 1 when a STOP_BITS value is supported (1 or 2)
// No ports; imported by the transmitter and receiver modules.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int BAUD_CNT_W = 16;

    function automatic int calc_bit_cycles(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic bit stop_bits_legal(input int stop_bits);
        return (stop_bits == 1) || (stop_bits == 2);
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Enable-gated bit-period counter. Counts 0..CYCLES-1 while enabled, wraps,
// and is held at 0 while disabled. o_bit_tick is high for the one cycle in
// which the count equals CYCLES-1 (the bit boundary).
// Ports:
//   clk_in     : system clock, rising edge
//   rst_in     : asynchronous active-high reset
//   i_en       : count enable; low clears the counter
//   o_bit_tick : one-cycle pulse at the last clock of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CYCLES = 16
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_en,
    output logic o_bit_tick
);

    logic [BAUD_CNT_W-1:0] r_count;
    logic                  w_at_end;

    assign w_at_end   = (r_count == BAUD_CNT_W'(CYCLES - 1));
    assign o_bit_tick = i_en && w_at_end;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (!i_en || w_at_end) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// UART byte transmitter: one byte per start handshake, sent LSB first as
// start bit, 8 data bits, optional parity bit and 1 or 2 stop bits.
// Ports:
//   clk_in   : system clock, rising edge
//   rst_in   : asynchronous active-high reset; aborts a frame in flight
//   tx_data  : byte to send, sampled only in the accept cycle
//   tx_start : request, accepted in any cycle where tx_busy is low
//   tx_busy  : high from the cycle after accept through the last stop cycle
//   tx_done  : one-cycle pulse in the cycle IDLE is re-entered
//   rs232_tx : registered serial line, idle high
// -----------------------------------------------------------------------------
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       rs232_tx
);

    localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);
    localparam bit P_ODD      = (PARITY_ODD != 0);
    localparam bit P_EN       = (PARITY_EN != 0);
    localparam bit TWO_STOP   = (STOP_BITS == 2);

    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $fatal(1, "uart_byte_tx: STOP_BITS must be 1 or 2");
    end
    if (BIT_CYCLES < 1 || BIT_CYCLES > (1 << BAUD_CNT_W)) begin : g_bad_bit_cycles
        $fatal(1, "uart_byte_tx: CLK_FREQ/BAUD_RATE out of counter range");
    end

    tx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bit_idx;
    logic       r_stop_idx;
    logic       r_parity;
    logic       r_tx;
    logic       r_busy;
    logic       r_done;
    logic       w_baud_en;
    logic       w_bit_tick;

    assign w_baud_en = (r_state != IDLE);

    uart_baud_gen #(
        .CYCLES (BIT_CYCLES)
    ) u_baud_gen (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .i_en       (w_baud_en),
        .o_bit_tick (w_bit_tick)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_stop_idx <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (tx_start) begin
                        r_shift    <= tx_data;
                        r_parity   <= (^tx_data) ^ P_ODD;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= START;
                    end
                end
                START: begin
                    // Present bit 0 at the end of the start bit, then keep
                    // the next data bit waiting in r_shift[0].
                    if (w_bit_tick) begin
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_state <= DATA;
                    end
                end
                DATA: begin
                    if (w_bit_tick) begin
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            if (P_EN) begin
                                r_tx    <= r_parity;
                                r_state <= PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= STOP;
                            end
                        end else begin
                            r_tx      <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_tick) begin
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_tick) begin
                        if (!TWO_STOP || r_stop_idx) begin
                            r_stop_idx <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rs232_tx = r_tx;
    assign tx_busy  = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_byte_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_byte_tx
// Four transmitter instances sharing one clock and reset:
//   0: 160 Hz / 10 baud, no parity, 1 stop
//   1: 160 Hz / 10 baud, even parity, 2 stop
//   2: 160 Hz / 10 baud, odd parity, 2 stop
//   3: 50 MHz / 9600 baud defaults
// Expected line bits are queued when a byte is launched and popped one per
// bit period while the line is watched every cycle.
// -----------------------------------------------------------------------------
module tb_uart_byte_tx;

    localparam int BC [4] = '{16, 16, 16, 5208};
    localparam int PE [4] = '{0, 1, 1, 0};
    localparam int PO [4] = '{0, 0, 1, 0};
    localparam int SB [4] = '{1, 2, 2, 1};

    logic       clk = 1'b0;
    logic       rst;
    logic       s_start [4];
    logic [7:0] s_data  [4];
    logic       w_line  [4];
    logic       w_busy  [4];
    logic       w_done  [4];

    int n_vec = 0;
    int n_err = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    uart_byte_tx #(.CLK_FREQ(160), .BAUD_RATE(10)) u0 (
        .clk_in(clk), .rst_in(rst), .tx_data(s_data[0]), .tx_start(s_start[0]),
        .tx_busy(w_busy[0]), .tx_done(w_done[0]), .rs232_tx(w_line[0]));

    uart_byte_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(0),
                   .STOP_BITS(2)) u1 (
        .clk_in(clk), .rst_in(rst), .tx_data(s_data[1]), .tx_start(s_start[1]),
        .tx_busy(w_busy[1]), .tx_done(w_done[1]), .rs232_tx(w_line[1]));

    uart_byte_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY_EN(1), .PARITY_ODD(1),
                   .STOP_BITS(2)) u2 (
        .clk_in(clk), .rst_in(rst), .tx_data(s_data[2]), .tx_start(s_start[2]),
        .tx_busy(w_busy[2]), .tx_done(w_done[2]), .rs232_tx(w_line[2]));

    uart_byte_tx u3 (
        .clk_in(clk), .rst_in(rst), .tx_data(s_data[3]), .tx_start(s_start[3]),
        .tx_busy(w_busy[3]), .tx_done(w_done[3]), .rs232_tx(w_line[3]));

    typedef struct {
        int         idx;
        logic [7:0] data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input int idx, input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (PE[idx] != 0) exp_q.push_back((^d) ^ (PO[idx] != 0));
        for (int i = 0; i < SB[idx]; i++) exp_q.push_back(1'b1);
    endtask

    // Drives the request and advances through the accept edge; returns in
    // the first start-bit cycle.
    task automatic start_frame(input int idx, input logic [7:0] d);
        s_data[idx]  = d;
        s_start[idx] = 1'b1;
        push_frame(idx, d);
        tick();
    endtask

    // Entered in the first start-bit cycle; returns in the tx_done cycle.
    // poke_at >= 0 raises tx_start with 0xFF for one cycle at that offset.
    task automatic watch_frame(input int idx, input string tag, input int poke_at);
        int   nbits;
        int   len;
        bit   e;
        logic got;
        logic busy_bad;
        logic done_bad;
        nbits    = 10 + PE[idx] + SB[idx] - 1;
        len      = nbits * BC[idx];
        e        = 1'b1;
        got      = 1'b1;
        busy_bad = 1'b0;
        done_bad = 1'b0;
        for (int c = 0; c < len; c++) begin
            if (c % BC[idx] == 0) begin
                e   = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
                got = e;
            end
            if (w_line[idx] !== e && got === e) got = w_line[idx];
            if (w_busy[idx] !== 1'b1) busy_bad = 1'b1;
            if (w_done[idx] !== 1'b0) done_bad = 1'b1;
            if (c % BC[idx] == BC[idx] - 1)
                check($sformatf("%s bit%0d", tag, c / BC[idx]), {31'd0, got}, {31'd0, e});
            if (poke_at >= 0 && c == poke_at) begin
                s_data[idx]  = 8'hFF;
                s_start[idx] = 1'b1;
            end else if (poke_at >= 0 && c == poke_at + 1) begin
                s_start[idx] = 1'b0;
            end
            tick();
        end
        check($sformatf("%s busy_in_frame", tag), {31'd0, busy_bad}, 32'd0);
        check($sformatf("%s early_done", tag), {31'd0, done_bad}, 32'd0);
        check($sformatf("%s done_pulse", tag), {31'd0, w_done[idx]}, 32'd1);
        check($sformatf("%s busy_fall", tag), {31'd0, w_busy[idx]}, 32'd0);
        check($sformatf("%s line_idle", tag), {31'd0, w_line[idx]}, 32'd1);
    endtask

    vec_t vecs [6];

    initial begin
        logic bad;
        vecs[0] = '{0, 8'hA5};
        vecs[1] = '{1, 8'h07};
        vecs[2] = '{2, 8'h07};
        vecs[3] = '{0, 8'h00};
        vecs[4] = '{0, 8'hFF};
        vecs[5] = '{1, 8'hC3};

        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_start[i] = 1'b0;
            s_data[i]  = 8'h00;
        end
        #2;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset line%0d", i), {31'd0, w_line[i]}, 32'd1);
            check($sformatf("reset busy%0d", i), {31'd0, w_busy[i]}, 32'd0);
            check($sformatf("reset done%0d", i), {31'd0, w_done[i]}, 32'd0);
        end
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Table of single frames.
        for (int v = 0; v < 6; v++) begin
            start_frame(vecs[v].idx, vecs[v].data);
            s_start[vecs[v].idx] = 1'b0;
            watch_frame(vecs[v].idx, $sformatf("vec%0d_%02h", v, vecs[v].data), -1);
            tick();
            check($sformatf("vec%0d done_one_cycle", v), {31'd0, w_done[vecs[v].idx]}, 32'd0);
        end

        // Request mid-frame must be ignored: one frame, one tx_done.
        start_frame(0, 8'h3C);
        s_start[0] = 1'b0;
        s_data[0]  = 8'h3C;
        watch_frame(0, "poke_3c", 50);
        bad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (w_line[0] !== 1'b1 || w_busy[0] !== 1'b0 || w_done[0] !== 1'b0) bad = 1'b1;
        end
        check("poke no_second_frame", {31'd0, bad}, 32'd0);

        // tx_start held high; data switched in the tx_done cycle.
        start_frame(0, 8'h55);
        watch_frame(0, "held_55", -1);
        s_data[0] = 8'hAA;
        push_frame(0, 8'hAA);
        tick();
        watch_frame(0, "held_aa", -1);
        s_start[0] = 1'b0;
        tick();
        check("held stop_after_release", {31'd0, w_busy[0]}, 32'd0);

        // Reset in data bit 4 of 0x00.
        start_frame(0, 8'h00);
        s_start[0] = 1'b0;
        repeat (88) tick();
        check("pre_reset line_bit4", {31'd0, w_line[0]}, 32'd0);
        rst = 1'b1;
        #1;
        check("async_reset line", {31'd0, w_line[0]}, 32'd1);
        check("async_reset busy", {31'd0, w_busy[0]}, 32'd0);
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (w_done[0] !== 1'b0 || w_line[0] !== 1'b1) bad = 1'b1;
        end
        rst = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 20; c++) begin
            tick();
            if (w_done[0] !== 1'b0 || w_line[0] !== 1'b1 || w_busy[0] !== 1'b0) bad = 1'b1;
        end
        check("reset no_done", {31'd0, bad}, 32'd0);
        start_frame(0, 8'h81);
        s_start[0] = 1'b0;
        watch_frame(0, "after_reset_81", -1);
        tick();

        // Default 50 MHz / 9600 baud: 5208-cycle bits.
        start_frame(3, 8'h00);
        s_start[3] = 1'b0;
        watch_frame(3, "baud9600_00", -1);
        tick();
        check("baud9600 done_one_cycle", {31'd0, w_done[3]}, 32'd0);

        check("scoreboard drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
UART byte transmitter, the transmit-side counterpart of the modbus RTU slave's byte receiver. Accepts one byte per start handshake. Serialises it LSB-first onto the uart pin as 1 start bit, 8 data bits, an optional parity bit and 1 or 2 stop bits. Feeds the slave's response path; the frame builder drives it one byte at a time, using tx_busy and tx_done.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate in bit/s
PARITY_EN, 0, 1 inserts a parity bit after data bit 7
PARITY_ODD, 0, parity sense when enabled: 0 even, 1 odd
STOP_BITS, 1, number of stop bits; legal values 1 or 2

Ports:
clk_in  input  1  system clock, all logic on rising edge
rst_in  input  1  asynchronous active-high reset
tx_data  input  8  byte to send; sampled only in the accept cycle
tx_start  input  1  request; accepted in any cycle where tx_busy=0
tx_busy  output  1  high from the cycle after accept through the last stop-bit cycle
tx_done  output  1  one-cycle pulse when the final stop bit completes
rs232_tx  output  1  serial line, idle high

Behaviour:
- One clock; reset is asynchronous and active-high. Ports are clk_in and rst_in.
- Reset values: rs232_tx=1, tx_busy=0, tx_done=0. State goes to IDLE and all counters to 0. Reset asserted mid-frame aborts the frame immediately and the line returns high; no tx_done pulse.
- BIT_CYCLES = CLK_FREQ/BAUD_RATE (integer division). Every bit, including the start bit, lasts exactly BIT_CYCLES clocks.
- Baud counter: 16 bits wide. Counts 0..BIT_CYCLES-1 while not IDLE, wraps to 0, and is held at 0 in IDLE. A bit boundary is the cycle where the counter equals BIT_CYCLES-1.
- Accept: in IDLE with tx_start=1, latch tx_data into a shift register. Compute parity = XOR(tx_data) XOR PARITY_ODD.
- Next cycle after accept: state=START, rs232_tx=0, tx_busy=1. Latency from the accept edge to the start-bit edge is one cycle.
- States and transitions:
  - IDLE -> START on accept.
  - START -> DATA at the bit boundary.
  - DATA: sends bits 0..7, LSB first, using a 3-bit bit index. After bit 7's boundary, go to PARITY if PARITY_EN, else to STOP.
  - PARITY -> STOP at the bit boundary.
  - STOP: line is 1 for STOP_BITS bit times, then -> IDLE.
- rs232_tx is driven from a register, so the output is glitch-free.
- tx_done=1 on the cycle after the last stop-bit boundary, which is the cycle IDLE is re-entered. tx_busy=0 in that same cycle.
- Frame length = (10 + PARITY_EN + STOP_BITS - 1) * BIT_CYCLES cycles, measured from the start-bit edge to the tx_done cycle.
- tx_start while tx_busy=1 is ignored. No queueing, and no effect on the frame in flight.
- tx_start in the tx_done cycle is accepted, giving back-to-back frames with no extra idle time beyond the stop bits.
- tx_data changes after the accept cycle do not affect the frame in flight.
- tx_start held high continuously produces consecutive frames, each sampling tx_data at its own accept cycle.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding localparams IDLE/START/DATA/PARITY/STOP;
  - the BIT_CYCLES derivation function;
  - the legal STOP_BITS range check, which stops elaboration if STOP_BITS is not 1 or 2. The receiver reuses this check.
- One natural sub-module, uart_baud_gen: enable-gated baud counter emitting a one-cycle bit_tick at BIT_CYCLES-1, held clear when disabled. Its parameter is the cycle count, so it can be reused in a future oversampled receiver.

Test Plan:
- Bench parameters CLK_FREQ=160, BAUD_RATE=10, so BIT_CYCLES=16. Send 0xA5, defaults -> line low 16 cycles, then bits 1,0,1,0,0,1,0,1, then high 16 cycles. tx_done pulses exactly 160 cycles after the start-bit edge, and tx_busy falls in the same cycle.
- PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2. Send 0x07 -> parity bit 1; total frame 192 cycles. Repeat with PARITY_ODD=1 -> parity bit 0.
- tx_start pulsed mid-frame with tx_data=0xFF while 0x3C is in flight -> the 0x3C frame is unchanged; no second frame and only one tx_done.
- tx_start held high with tx_data 0x55 then 0xAA, switched on the tx_done cycle -> second start bit begins the cycle after tx_done, and the line carries 0x55 then 0xAA correctly.
- rst_in asserted at data bit 4 of 0x00 -> rs232_tx=1 and tx_busy=0 asynchronously, no tx_done. A fresh tx_start of 0x81 after reset release yields a correct full frame.
- Defaults 50 MHz/9600: send 0x00 -> every bit measured as 5208 cycles.
